// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed seven-segment scan controller for NUM_DIGITS common-anode digits
// Ports: clk, rst (sync, active-low); en, load, val, dp_in, lz_blank, blink_mask, bright in;
//   seg, dp, an (all active-low), frame_start (one pulse per frame), pending (shadow not yet committed) out.
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SYS_CLK_FREQ = 100000000,
   parameter int DIGIT_RATE   = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] val,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_blank,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic [3:0]              bright,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start,
   output logic                    pending
);
   localparam int TICK_DIV = SYS_CLK_FREQ / DIGIT_RATE;
   localparam int SLOT_LEN = (TICK_DIV - BLANK_CYCLES) / 16;
   localparam int CW = $clog2(TICK_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   // active-low gfedcba glyphs, index 15 (F) first
   localparam logic [15:0][6:0] GLYPH = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                         7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [BW-1:0]           bcnt;
   logic                    blink_ph;
   logic [4*NUM_DIGITS-1:0] disp_val, sh_val;
   logic [NUM_DIGITS-1:0]   disp_dp, sh_dp;
   logic [NUM_DIGITS-1:0]   lz;
   logic                    tick, wrap, z, supp, lit, blink_end;
   logic [3:0]              nib;
   int                      pos;
   logic [6:0]              seg_n;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an_n;
   always_comb begin
      tick = cnt == CW'(TICK_DIV - 1);
      wrap = tick && idx == IW'(NUM_DIGITS - 1);
      blink_end = bcnt == BW'(BLINK_FRAMES - 1);
      nib = disp_val[4*idx +: 4];
      // lz[i] set when nibbles i..top are all zero; digit 0 is never suppressed
      lz = '0;
      z = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         z = z && disp_val[4*i +: 4] == 4'h0;
         lz[i] = z;
      end
      supp = lz_blank && lz[idx];
      // PWM: slots up to and including bright are on; the remainder past slot 15 never qualifies
      pos = int'(cnt) - BLANK_CYCLES;
      // a suppressed digit still lights its anode when its decimal point is on
      lit = en && pos >= 0 && pos < (int'(bright) + 1) * SLOT_LEN
            && !(blink_ph && blink_mask[idx]) && !(supp && !disp_dp[idx]);
      seg_n = lit && !supp ? GLYPH[nib] : 7'h7F;
      dp_n = !(lit && disp_dp[idx]);
      an_n = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
         idx <= '0;
         bcnt <= '0;
         blink_ph <= 1'b0;
         disp_val <= '0;
         disp_dp <= '0;
         sh_val <= '0;
         sh_dp <= '0;
         pending <= 1'b0;
         frame_start <= 1'b0;
         seg <= 7'h7F;
         dp <= 1'b1;
         an <= '1;
      end else begin
         cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) idx <= wrap ? '0 : idx + IW'(1);
         frame_start <= wrap;
         if (load) begin
            sh_val <= val;
            sh_dp <= dp_in;
         end
         // a load on the wrap cycle commits the old shadow and keeps pending for the new one
         pending <= load || (pending && !wrap);
         if (wrap) begin
            disp_val <= sh_val;
            disp_dp <= sh_dp;
            bcnt <= blink_end ? '0 : bcnt + BW'(1);
            blink_ph <= blink_ph ^ blink_end;
         end
         seg <= seg_n;
         dp <= dp_n;
         an <= an_n;
      end
   end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl (4 digits, 64-cycle dwell, 3-cycle slots)
module tb_display_scan_ctrl;
   localparam int DWELL = 64;
   localparam int FRAME = 256;
   logic        clk = 0, rst = 0, en = 1, load = 0, lz_blank = 0;
   logic [15:0] val = '0;
   logic [3:0]  dp_in = '0, blink_mask = '0, bright = 4'd15;
   logic [6:0]  seg;
   logic        dp, frame_start, pending;
   logic [3:0]  an;
   int          n_vec = 0, n_miss = 0;
   typedef struct {
      int f; int d; int lo;
      logic [3:0] an; logic [6:0] seg; logic dp;
      string nm;
   } exp_t;
   exp_t sb[$];
   int          mon_fr = -1, k = 0, acc_lo = 0;
   logic [3:0]  acc_an;
   logic [6:0]  acc_seg;
   logic        acc_dp, acc_bad;
   display_scan_ctrl #(.NUM_DIGITS(4), .SYS_CLK_FREQ(6400), .DIGIT_RATE(100),
                       .BLANK_CYCLES(16), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dp_in(dp_in),
      .lz_blank(lz_blank), .blink_mask(blink_mask), .bright(bright),
      .seg(seg), .dp(dp), .an(an), .frame_start(frame_start), .pending(pending)
   );
   always #5 clk = ~clk;
   task automatic clr();
      acc_lo = 0; acc_an = 4'hF; acc_seg = 7'h7F; acc_dp = 1'b1; acc_bad = 1'b0;
   endtask
   // one dwell summary: lit-cycle count, the anode/seg/dp seen while lit, and any inconsistency
   task automatic acc();
      if (an != 4'hF) begin
         if (acc_lo == 0) begin
            acc_an = an; acc_seg = seg; acc_dp = dp;
         end else if (an != acc_an || seg != acc_seg || dp != acc_dp) acc_bad = 1'b1;
         acc_lo++;
      end else if (seg != 7'h7F || dp != 1'b1) acc_bad = 1'b1;
   endtask
   task automatic close_dwell(input int f, input int d);
      exp_t e;
      while (sb.size() > 0 && (sb[0].f < f || (sb[0].f == f && sb[0].d < d))) begin
         e = sb.pop_front();
         n_vec++; n_miss++;
         $display("FAIL %s f%0d d%0d: dwell never observed, monitor now at f%0d d%0d", e.nm, e.f, e.d, f, d);
      end
      if (sb.size() > 0 && sb[0].f == f && sb[0].d == d) begin
         e = sb.pop_front();
         n_vec++;
         if (acc_bad || acc_lo != e.lo || acc_an != e.an || acc_seg != e.seg || acc_dp != e.dp) begin
            n_miss++;
            $display("FAIL %s f%0d d%0d: got lo=%0d an=%b seg=%b dp=%b unsteady=%0d, want lo=%0d an=%b seg=%b dp=%b",
                     e.nm, f, d, acc_lo, acc_an, acc_seg, acc_dp, acc_bad, e.lo, e.an, e.seg, e.dp);
         end
      end
   endtask
   // outputs lag state by one cycle, so digit d covers samples 64d+1..64d+64 after frame_start
   always @(negedge clk) begin
      if (!rst) begin
         mon_fr = -1; k = 0; clr();
      end else if (frame_start) begin
         if (mon_fr >= 0) begin
            acc();
            close_dwell(mon_fr, 3);
            n_vec++;
            if (k != FRAME - 1) begin
               n_miss++;
               $display("FAIL frame_period: got %0d cycles want %0d", k + 1, FRAME);
            end
         end
         mon_fr++; k = 0; clr();
      end else if (mon_fr >= 0) begin
         k++;
         acc();
         if (k >= FRAME) begin
            n_vec++; n_miss++;
            $display("FAIL frame_period: no frame_start after %0d cycles want %0d", k, FRAME);
            mon_fr = -1;
         end else if (k % DWELL == 0) begin
            close_dwell(mon_fr, k / DWELL - 1);
            clr();
         end
      end
   end
   task automatic nxt();
      @(negedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask
   task automatic push(input int f, input int d, input int lo, input logic [3:0] a,
                       input logic [6:0] s, input logic p, input string nm);
      exp_t e;
      e.f = f; e.d = d; e.lo = lo; e.an = a; e.seg = s; e.dp = p; e.nm = nm;
      sb.push_back(e);
   endtask
   task automatic wait_fs(output bit pend_all);
      int c;
      c = 0;
      pend_all = 1'b1;
      do begin
         nxt();
         if (!frame_start) pend_all &= pending;
         c++;
      end while (!frame_start && c < 400);
      if (!frame_start) begin
         n_vec++; n_miss++;
         $display("FAIL frame_start_timeout: got none in %0d cycles want one", c);
      end
   endtask
   // reset for 3 cycles, check reset outputs, then time the first lit anode (blank 16 + 1 latency)
   task automatic reset_seq(input string tag);
      int c;
      rst = 0;
      repeat (3) nxt();
      chk({tag, "_rst_an"}, 32'(an), 32'hF);
      chk({tag, "_rst_seg"}, 32'(seg), 32'h7F);
      chk({tag, "_rst_dp"}, 32'(dp), 32'h1);
      chk({tag, "_rst_pending"}, 32'(pending), 32'h0);
      chk({tag, "_rst_fs"}, 32'(frame_start), 32'h0);
      rst = 1;
      c = 0;
      while (an == 4'hF && c < 100) begin
         nxt();
         c++;
      end
      chk({tag, "_first_an_cycle"}, 32'(c), 32'd17);
      chk({tag, "_first_an"}, 32'(an), 32'b1110);
      chk({tag, "_first_seg"}, 32'(seg), 32'h40);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      bit pa;
      int f;
      logic [6:0] dark;
      dark = 7'b1100110;
      reset_seq("pwr");
      repeat (80) nxt();
      val = 16'hFFFF; dp_in = 4'hF; load = 1; nxt(); load = 0;
      chk("pending_before_rst", 32'(pending), 32'h1);
      reset_seq("mid");
      val = 16'h12AF; dp_in = 4'b0001; bright = 4'd15; load = 1; nxt(); load = 0;
      chk("pending_after_load", 32'(pending), 32'h1);
      wait_fs(pa);
      chk("pending_held", 32'(pa), 32'h1);
      chk("pending_commit", 32'(pending), 32'h0);
      push(mon_fr, 0, 48, 4'b1110, 7'h0E, 1'b0, "ld_d0");
      push(mon_fr, 1, 48, 4'b1101, 7'h08, 1'b1, "ld_d1");
      push(mon_fr, 2, 48, 4'b1011, 7'h24, 1'b1, "ld_d2");
      push(mon_fr, 3, 48, 4'b0111, 7'h79, 1'b1, "ld_d3");
      wait_fs(pa);
      bright = 4'd0;
      push(mon_fr, 0, 3, 4'b1110, 7'h0E, 1'b0, "br0_d0");
      push(mon_fr, 1, 3, 4'b1101, 7'h08, 1'b1, "br0_d1");
      push(mon_fr, 2, 3, 4'b1011, 7'h24, 1'b1, "br0_d2");
      push(mon_fr, 3, 3, 4'b0111, 7'h79, 1'b1, "br0_d3");
      wait_fs(pa);
      bright = 4'd7;
      push(mon_fr, 0, 24, 4'b1110, 7'h0E, 1'b0, "br7_d0");
      push(mon_fr, 3, 24, 4'b0111, 7'h79, 1'b1, "br7_d3");
      wait_fs(pa);
      bright = 4'd15; lz_blank = 1; val = 16'h0050; dp_in = 4'b0000; load = 1;
      f = mon_fr;
      nxt(); load = 0;
      push(f + 1, 0, 48, 4'b1110, 7'h40, 1'b1, "lz_d0");
      push(f + 1, 1, 48, 4'b1101, 7'h12, 1'b1, "lz_d1");
      push(f + 1, 2, 0, 4'b1111, 7'h7F, 1'b1, "lz_d2");
      push(f + 1, 3, 0, 4'b1111, 7'h7F, 1'b1, "lz_d3");
      wait_fs(pa);
      wait_fs(pa);
      lz_blank = 0; val = 16'h4321; load = 1; nxt(); load = 0;
      chk("wrapld_pend_a", 32'(pending), 32'h1);
      repeat (254) nxt();
      val = 16'h8765; load = 1; nxt(); load = 0;
      chk("wrapld_fs", 32'(frame_start), 32'h1);
      chk("wrapld_pend_b", 32'(pending), 32'h1);
      f = mon_fr;
      push(f, 0, 48, 4'b1110, 7'h79, 1'b1, "wrapA_d0");
      push(f, 1, 48, 4'b1101, 7'h24, 1'b1, "wrapA_d1");
      push(f, 2, 48, 4'b1011, 7'h30, 1'b1, "wrapA_d2");
      push(f, 3, 48, 4'b0111, 7'h19, 1'b1, "wrapA_d3");
      push(f + 1, 0, 48, 4'b1110, 7'h12, 1'b1, "wrapB_d0");
      push(f + 1, 1, 48, 4'b1101, 7'h02, 1'b1, "wrapB_d1");
      push(f + 1, 2, 48, 4'b1011, 7'h78, 1'b1, "wrapB_d2");
      push(f + 1, 3, 48, 4'b0111, 7'h00, 1'b1, "wrapB_d3");
      wait_fs(pa);
      chk("wrapld_pend_held", 32'(pa), 32'h1);
      chk("wrapld_pend_clr", 32'(pending), 32'h0);
      wait_fs(pa);
      blink_mask = 4'b1000;
      reset_seq("blk");
      wait_fs(pa);
      f = mon_fr;
      for (int i = 0; i < 7; i++) begin
         push(f + i, 0, 48, 4'b1110, 7'h40, 1'b1, "blk_d0");
         push(f + i, 3, dark[i] ? 0 : 48, dark[i] ? 4'b1111 : 4'b0111,
              dark[i] ? 7'h7F : 7'h40, 1'b1, "blk_d3");
      end
      repeat (7) wait_fs(pa);
      en = 0;
      push(mon_fr, 0, 0, 4'b1111, 7'h7F, 1'b1, "en0_d0");
      push(mon_fr, 2, 0, 4'b1111, 7'h7F, 1'b1, "en0_d2");
      wait_fs(pa);
      en = 1;
      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
